bit_serializer: RTL and testbench

Parallel-to-serial front end that feeds the serial `data` input of the downstream sequence detector. It accepts one WIDTH-bit word per valid/ready handshake and emits it one bit per clock on `data`. An optional even-parity bit can be appended after each word. It supports gap-free back-to-back words so that the detector sees a continuous bitstream.

---
 rtl/bit_serializer.sv | 140 ++++++++++++++
 tb/tb_bit_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word per valid/ready handshake, one bit per clock on data.
// Latency: first bit on data the cycle after accept; back-to-back words without a bubble. Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_LEVEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_done
);
    localparam int   CW       = $clog2(WIDTH) + 1;
    localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic             load;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

`ifdef BIT_SERIALIZER_PARITY_EN
    assign in_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
    // Ready during the last payload bit lets the next word follow with no gap.
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && (cnt_q == '0));
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        data_d       = IDLE_BIT;
        data_valid_d = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        load         = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) load = 1'b1;
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    data_d       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d      = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d        = cnt_q - CW'(1);
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                    frame_done_d = (cnt_q == CW'(1));
`endif
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d      = S_PARITY;
                    data_d       = parity_q;
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    frame_done_d = 1'b1;
`else
                    if (accept) load = 1'b1;
                    else        state_d = S_IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (accept) load = 1'b1;
                else        state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // First bit goes straight to data; the rest wait in the shift register.
        if (load) begin
            state_d      = S_SHIFT;
            data_d       = (MSB_FIRST != 0) ? in_data[WIDTH-1] : in_data[0];
            shreg_d      = (MSB_FIRST != 0) ? (in_data << 1) : (in_data >> 1);
            cnt_d        = CW'(WIDTH - 1);
            data_valid_d = 1'b1;
            busy_d       = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_d     = ^in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            data_q       <= IDLE_BIT;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and are checked
// every cycle against a queue-of-expected-bits model, plus literal serialization checks.
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FLEN = 9;
    localparam logic [63:0] EXP_D0_M  = 64'h1A1;   // 1101_0000 + parity 1
    localparam logic [63:0] EXP_0B_M  = 64'h017;   // 0000_1011 + parity 1
    localparam logic [63:0] EXP_B2B_M = 64'h2D678; // B5,1,3C,0
`else
    localparam int FLEN = 8;
    localparam logic [63:0] EXP_D0_M  = 64'hD0;
    localparam logic [63:0] EXP_0B_M  = 64'h0B;
    localparam logic [63:0] EXP_B2B_M = 64'hB53C;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic rdy_m, data_m, vld_m, busy_m, fd_m;
    logic rdy_l, data_l, vld_l, busy_l, fd_l;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0)) u_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .data(data_m), .data_valid(vld_m), .busy(busy_m), .frame_done(fd_m));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0)) u_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .data(data_l), .data_valid(vld_l), .busy(busy_l), .frame_done(fd_l));

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;
    bit qm[$];
    bit ql[$];
    logic [63:0] cap_m, cap_l;
    int n_fd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of bits still to appear on data, front = bit currently on data.
    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            qm.delete();
            ql.delete();
            check_en = 1;
        end else begin
            acc = in_valid && (qm.size() <= 1);
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    qm.push_back(in_data[7-i]);
                    ql.push_back(in_data[i]);
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                qm.push_back(^in_data);
                ql.push_back(^in_data);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready_m",   rdy_m,  qm.size() <= 1);
            chk("data_m",       data_m, (qm.size() > 0) ? qm[0] : 1'b0);
            chk("data_valid_m", vld_m,  qm.size() > 0);
            chk("busy_m",       busy_m, qm.size() > 0);
            chk("frame_done_m", fd_m,   qm.size() == 1);
            chk("in_ready_l",   rdy_l,  ql.size() <= 1);
            chk("data_l",       data_l, (ql.size() > 0) ? ql[0] : 1'b0);
            chk("data_valid_l", vld_l,  ql.size() > 0);
            chk("busy_l",       busy_l, ql.size() > 0);
            chk("frame_done_l", fd_l,   ql.size() == 1);
        end
        if (vld_m) cap_m = {cap_m[62:0], data_m};
        if (vld_l) cap_l = {cap_l[62:0], data_l};
        if (fd_m) n_fd++;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] w);
        logic ok;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50; i++) begin
            ok = rdy_m;
            step();
            if (ok) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: word %0h not accepted within 50 cycles", w);
    endtask

    task automatic clear_caps();
        cap_m = '0;
        cap_l = '0;
        n_fd  = 0;
    endtask

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        clear_caps();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        idle(3);

        // Single word, MSB and LSB ordering
        clear_caps();
        send(8'hD0);
        chk("model_len_d0", qm.size(), FLEN);
        chk("model_first_d0", qm[0], 1'b1);
        idle(12);
        chk("ser_d0_msb", cap_m & mask(FLEN), EXP_D0_M);
        chk("ser_d0_lsb", cap_l & mask(FLEN), EXP_0B_M);
        chk("frame_done_count_single", n_fd, 1);

        clear_caps();
        send(8'h0B);
        idle(12);
        chk("ser_0b_lsb", cap_l & mask(FLEN), EXP_D0_M);
        chk("ser_0b_msb", cap_m & mask(FLEN), EXP_0B_M);

        // Back-to-back
        clear_caps();
        send(8'hB5);
        send(8'h3C);
        idle(24);
        chk("ser_b2b_msb", cap_m & mask(2 * FLEN), EXP_B2B_M);
        chk("frame_done_count_b2b", n_fd, 2);

        // Reset in mid-frame, then a clean frame
        clear_caps();
        send(8'hFF);
        idle(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("after_reset_data", data_m, 1'b0);
        chk("after_reset_valid", vld_m, 1'b0);
        chk("after_reset_busy", busy_m, 1'b0);
        send(8'hD0);
        idle(12);
        chk("ser_d0_after_reset", cap_m & mask(FLEN), EXP_D0_M);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 8'($urandom);
            step();
        end
        reset = 1'b0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
